// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry block: FSM states, operator codes and
// a small helper used to size-check the operand registers.
package operand_entry_pkg;

   typedef enum logic [1:0] {
      StEnterA = 2'd0,
      StEnterB = 2'd1,
      StDone   = 2'd2
   } state_e;

   localparam logic [1:0] STATE_ENTER_A = 2'd0;
   localparam logic [1:0] STATE_ENTER_B = 2'd1;
   localparam logic [1:0] STATE_DONE    = 2'd2;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_BKSP = 3'd7;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/operand_entry_if.sv
// Key inputs and operand/status outputs of operand_entry; the keypad side is the master.
interface operand_entry_if #(
   parameter int unsigned MAX_DIGITS = 3,
   parameter int unsigned WIDTH      = 10
);
   localparam int unsigned DIGW = $clog2(MAX_DIGITS + 1);

   logic [3:0]       num;
   logic             num_pressed;
   logic [2:0]       opt;
   logic             opt_pressed;
   logic             submit;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic [2:0]       op;
   logic [DIGW-1:0]  digits;
   logic [1:0]       state;
   logic             expr_valid;

   modport master (
      output num, num_pressed, opt, opt_pressed, submit,
      input  operand_a, operand_b, op, digits, state, expr_valid
   );

   modport slave (
      input  num, num_pressed, opt, opt_pressed, submit,
      output operand_a, operand_b, op, digits, state, expr_valid
   );

endinterface

// File: rtl/key_sync.sv
// Two-flop synchroniser for a key level plus its code, with a one-cycle rising-edge pulse.
// Code bits travel with the level so the code seen with the pulse is the synchronised one.
module key_sync #(
   parameter int unsigned DW = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          level,
   input  logic [DW-1:0] data,
   output logic          pulse,
   output logic [DW-1:0] data_sync
);

   logic [DW:0] s1_q, s2_q;
   logic        s3_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= {level, data};
         s2_q <= s1_q;
         s3_q <= s2_q[DW];
      end
   end

   assign pulse     = s2_q[DW] & ~s3_q;
   assign data_sync = s2_q[DW-1:0];

endmodule

// File: rtl/operand_entry.sv
// Calculator operand entry: builds operand_a, op and operand_b from debounced key levels.
// Define OPERAND_ENTRY_BKSP_EN to make operator code 7 act as backspace.
module operand_entry
   import operand_entry_pkg::*;
#(
   parameter int unsigned MAX_DIGITS = 3,
   parameter int unsigned WIDTH      = 10
) (
   input logic            clk,
   input logic            reset,
   operand_entry_if.slave bus
);

   localparam int unsigned     DIGW    = $clog2(MAX_DIGITS + 1);
   localparam logic [DIGW-1:0] MAX_CNT = DIGW'(MAX_DIGITS);

   generate
      if (WIDTH < 64 && (64'd1 << WIDTH) < pow10(MAX_DIGITS)) begin : g_width_check
         $error("WIDTH too small to hold 10**MAX_DIGITS-1");
      end
   endgenerate

   logic       num_pulse, opt_pulse, sub_pulse, sub_flag;
   logic [3:0] num_code;
   logic [2:0] opt_code;

   key_sync #(.DW(4)) u_num_sync (
      .clk       (clk),
      .reset     (reset),
      .level     (bus.num_pressed),
      .data      (bus.num),
      .pulse     (num_pulse),
      .data_sync (num_code)
   );

   key_sync #(.DW(3)) u_opt_sync (
      .clk       (clk),
      .reset     (reset),
      .level     (bus.opt_pressed),
      .data      (bus.opt),
      .pulse     (opt_pulse),
      .data_sync (opt_code)
   );

   key_sync #(.DW(1)) u_sub_sync (
      .clk       (clk),
      .reset     (reset),
      .level     (bus.submit),
      .data      (1'b1),
      .pulse     (sub_pulse),
      .data_sync (sub_flag)
   );

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       op_q;
   logic [DIGW-1:0]  digits_q;
   logic             expr_valid_q;
`ifdef OPERAND_ENTRY_BKSP_EN
   logic [DIGW-1:0]  a_digits_q;
`endif

   logic             num_evt, sub_evt, opt_arith;
   logic [WIDTH-1:0] cur_opnd, next_opnd;
   logic             counts;

   assign num_evt   = num_pulse & (num_code < 4'd10);
   assign sub_evt   = sub_pulse & sub_flag;
   assign opt_arith = ~opt_code[2];
   assign cur_opnd  = (state_q == StEnterA) ? a_q : b_q;
   assign next_opnd = cur_opnd * WIDTH'(10) + WIDTH'(num_code);
   // Leading zeros leave the significant-digit count unchanged.
   assign counts    = (cur_opnd != '0) || (num_code != 4'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StEnterA;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= OP_ADD;
         digits_q     <= '0;
         expr_valid_q <= 1'b0;
`ifdef OPERAND_ENTRY_BKSP_EN
         a_digits_q   <= '0;
`endif
      end else begin
         expr_valid_q <= 1'b0;
         if (sub_evt) begin
            if (state_q == StEnterB) begin
               state_q      <= StDone;
               expr_valid_q <= 1'b1;
            end
         end else if (opt_pulse) begin
            if (opt_arith) begin
               if (state_q == StEnterA) begin
                  op_q     <= opt_code;
                  digits_q <= '0;
                  state_q  <= StEnterB;
`ifdef OPERAND_ENTRY_BKSP_EN
                  a_digits_q <= digits_q;
`endif
               end else if (state_q == StEnterB && b_q == '0 && digits_q == '0) begin
                  op_q <= opt_code;
               end
            end
`ifdef OPERAND_ENTRY_BKSP_EN
            else if (opt_code == OP_BKSP && state_q != StDone) begin
               if (digits_q != '0) begin
                  if (state_q == StEnterA) a_q <= a_q / WIDTH'(10);
                  else                     b_q <= b_q / WIDTH'(10);
                  digits_q <= digits_q - DIGW'(1);
               end else if (state_q == StEnterB) begin
                  state_q  <= StEnterA;
                  op_q     <= OP_ADD;
                  digits_q <= a_digits_q;
               end
            end
`endif
         end else if (num_evt) begin
            unique case (state_q)
               StEnterA, StEnterB: begin
                  if (digits_q < MAX_CNT) begin
                     if (state_q == StEnterA) a_q <= next_opnd;
                     else                     b_q <= next_opnd;
                     if (counts) digits_q <= digits_q + DIGW'(1);
                  end
               end
               default: begin
                  state_q  <= StEnterA;
                  a_q      <= WIDTH'(num_code);
                  b_q      <= '0;
                  op_q     <= OP_ADD;
                  digits_q <= (num_code != 4'd0) ? DIGW'(1) : '0;
               end
            endcase
         end
      end
   end

   assign bus.operand_a  = a_q;
   assign bus.operand_b  = b_q;
   assign bus.op         = op_q;
   assign bus.digits     = digits_q;
   assign bus.state      = state_q;
   assign bus.expr_valid = expr_valid_q;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: completed expressions are queued when submit is
// pressed and compared when expr_valid pulses; register state is checked after each key.
module tb_operand_entry;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   typedef struct {
      int a;
      int b;
      int op;
   } expr_t;
   expr_t sb[$];

   operand_entry_if #(.MAX_DIGITS(3), .WIDTH(10)) bus ();

   operand_entry #(.MAX_DIGITS(3), .WIDTH(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input longint unsigned got,
                        input longint unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_regs(input string p, input int a, input int b, input int op,
                             input int dg, input int st);
      check({p, "_a"}, bus.operand_a, a);
      check({p, "_b"}, bus.operand_b, b);
      check({p, "_op"}, bus.op, op);
      check({p, "_digits"}, bus.digits, dg);
      check({p, "_state"}, bus.state, st);
   endtask

   // Every expr_valid must match a queued expectation; extra pulses are errors.
   always @(negedge clk) begin
      if (bus.expr_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            expr_t e;
            e = sb.pop_front();
            check("valid_a", bus.operand_a, e.a);
            check("valid_b", bus.operand_b, e.b);
            check("valid_op", bus.op, e.op);
            check("valid_state", bus.state, 2);
         end
      end
   end

   task automatic press(input bit pn, input bit po, input bit ps, input logic [3:0] d,
                        input logic [2:0] o);
      @(negedge clk);
      bus.num = d;
      bus.opt = o;
      @(negedge clk);
      bus.num_pressed = pn;
      bus.opt_pressed = po;
      bus.submit      = ps;
      repeat (5) @(negedge clk);
      bus.num_pressed = 1'b0;
      bus.opt_pressed = 1'b0;
      bus.submit      = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic press_num(input logic [3:0] d);
      press(1'b1, 1'b0, 1'b0, d, 3'd0);
   endtask

   task automatic press_opt(input logic [2:0] o);
      press(1'b0, 1'b1, 1'b0, 4'd0, o);
   endtask

   task automatic press_sub();
      press(1'b0, 1'b0, 1'b1, 4'd0, 3'd0);
   endtask

   task automatic push(input int a, input int b, input int op);
      expr_t e;
      e.a  = a;
      e.b  = b;
      e.op = op;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset           = 1'b0;
      bus.num         = 4'd0;
      bus.num_pressed = 1'b0;
      bus.opt         = 3'd0;
      bus.opt_pressed = 1'b0;
      bus.submit      = 1'b0;
      repeat (3) @(negedge clk);
      check_regs("reset", 0, 0, 0, 0, 0);
      check("reset_valid", bus.expr_valid, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Latency: level sampled on edge 1, registers move on edge 3, held key acts once.
      bus.num = 4'd1;
      @(negedge clk);
      bus.num_pressed = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("lat_edge2", bus.operand_a, 0);
      @(negedge clk);
      check("lat_edge3", bus.operand_a, 1);
      repeat (4) @(negedge clk);
      bus.num_pressed = 1'b0;
      repeat (4) @(negedge clk);
      check("held_once", bus.operand_a, 1);

      press_num(4'd2);
      press_num(4'd3);
      check_regs("a123", 123, 0, 0, 3, 0);
      press_opt(3'd0);
      press_num(4'd4);
      press_num(4'd5);
      push(123, 45, 0);
      press_sub();
      check_regs("done1", 123, 45, 0, 2, 2);

      press_num(4'd6);
      check_regs("restart", 6, 0, 0, 1, 0);
      press_sub();
      check("sub_in_a_state", bus.state, 0);

      do_reset();
      press_num(4'd0);
      press_num(4'd0);
      check_regs("lead0", 0, 0, 0, 0, 0);
      press_num(4'd7);
      press_num(4'd8);
      press_num(4'd9);
      press_num(4'd5);
      check_regs("cap", 789, 0, 0, 3, 0);
      press_num(4'd12);
      check("ignored_code", bus.operand_a, 789);

      press(1'b1, 1'b1, 1'b0, 4'd4, 3'd1);
      check_regs("opt_vs_digit", 789, 0, 1, 0, 1);
      press_opt(3'd3);
      check("op_replace", bus.op, 3);
      press_num(4'd2);
      press_opt(3'd0);
      check("op_locked", bus.op, 3);
      press_opt(3'd5);
      check("op_reserved", bus.op, 3);
      push(789, 2, 3);
      press(1'b1, 1'b0, 1'b1, 4'd9, 3'd0);
      check_regs("sub_vs_digit", 789, 2, 3, 1, 2);
      press_opt(3'd1);
      check_regs("opt_in_done", 789, 2, 3, 1, 2);
      press_sub();
      check("sub_in_done", bus.state, 2);

      do_reset();
      press_num(4'd1);
      press_num(4'd2);
      press_opt(3'd2);
      press_opt(3'd7);
      press_opt(3'd7);
`ifdef OPERAND_ENTRY_BKSP_EN
      check_regs("bksp", 1, 0, 0, 1, 0);
`else
      check_regs("bksp", 12, 0, 2, 0, 1);
`endif

      // Reset while digit 5 sits in the synchroniser, during a partial operand_b.
      do_reset();
      press_num(4'd1);
      press_opt(3'd0);
      press_num(4'd3);
      @(negedge clk);
      bus.num = 4'd5;
      @(negedge clk);
      bus.num_pressed = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      bus.num_pressed = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      check_regs("mid_reset", 0, 0, 0, 0, 0);

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
